// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with a one-entry holding
// register, ready/ack handshake and sticky framing/overrun flags.
module spart_rx #(
    parameter int DIV0 = 1302,
    parameter int DIV1 = 651,
    parameter int DIV2 = 326,
    parameter int DIV3 = 163
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] br_cfg,
    input  logic       rd_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t      state_q, state_d;
    logic        meta_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d, div_m1;
    logic [3:0]  samp_q, samp_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d, data_q, data_d;
    logic        rda_q, rda_d, fe_q, fe_d, ovr_q, ovr_d;
    logic        tick, start_det, go_data, shift_en, deliver, fe_set, ovr_set;

    always_comb begin
        unique case (br_cfg)
            2'd0: div_m1 = CW'(DIV0 - 1);
            2'd1: div_m1 = CW'(DIV1 - 1);
            2'd2: div_m1 = CW'(DIV2 - 1);
            default: div_m1 = CW'(DIV3 - 1);
        endcase
    end

    assign tick = (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!rxs_q) state_d = START;
            START: if (tick && samp_q == 4'd7) state_d = rxs_q ? IDLE : DATA;
            DATA:  if (tick && samp_q == 4'd15 && bit_q == 3'd7) state_d = STOP;
            STOP:  if (tick && samp_q == 4'd15) state_d = rxs_q ? IDLE : BRK;
            BRK:   if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != IDLE);
        start_det = (state_q == IDLE) && !rxs_q;
        go_data   = (state_q == START) && tick && samp_q == 4'd7 && !rxs_q;
        shift_en  = (state_q == DATA) && tick && samp_q == 4'd15;
        deliver   = (state_q == STOP) && tick && samp_q == 4'd15 && rxs_q;
        fe_set    = (state_q == STOP) && tick && samp_q == 4'd15 && !rxs_q;
    end

    // Holding register: an ack in the delivery cycle frees the slot for the new byte
    always_comb begin
        cnt_d   = (start_det || tick) ? div_m1 : cnt_q - CW'(1);
        samp_d  = (start_det || go_data) ? 4'd0 : (tick ? samp_q + 4'd1 : samp_q);
        bit_d   = go_data ? 3'd0 : (shift_en ? bit_q + 3'd1 : bit_q);
        sh_d    = shift_en ? {rxs_q, sh_q[7:1]} : sh_q;
        rda_d   = rda_q && !rd_ack;
        data_d  = data_q;
        ovr_set = deliver && rda_q && !rd_ack;
        if (deliver && (!rda_q || rd_ack)) begin
            rda_d  = 1'b1;
            data_d = sh_q;
        end
        fe_d  = fe_set  || (fe_q  && !err_clr);
        ovr_d = ovr_set || (ovr_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            cnt_q  <= CW'(DIV0 - 1);
            samp_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            data_q <= '0;
            rda_q  <= 1'b0;
            fe_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            meta_q <= rxd;
            rxs_q  <= meta_q;
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            data_q <= data_d;
            rda_q  <= rda_d;
            fe_q   <= fe_d;
            ovr_q  <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rda       = rda_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: frames are driven bit by bit, expected bytes
// are queued at send time and a monitor compares each delivered byte.
module tb_spart_rx;
    localparam int D0 = 4, D1 = 3, D2 = 2, D3 = 1;

    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1;
    logic [1:0] br_cfg = 2'd0;
    logic       rd_ack = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rda, busy, frame_err, overrun;

    int checks = 0, passed = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spart_rx #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .br_cfg(br_cfg), .rd_ack(rd_ack),
        .err_clr(err_clr), .rx_data(rx_data), .rda(rda), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input logic v, input int bt);
        @(negedge clk);
        rxd = v;
        repeat (bt - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int bt, input bit expect_ok);
        if (expect_ok) exp_q.push_back(d);
        send_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) send_bit(d[i], bt);
        send_bit(stop, bt);
    endtask

    task automatic wait_rda(input int max, output int n);
        n = 0;
        while (!rda && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Monitor: a new byte is present when rda rises, or stays high across an ack
    initial begin
        logic ack_s, rst_s, rda_prev;
        rda_prev = 1'b0;
        forever begin
            @(posedge clk);
            ack_s = rd_ack;
            rst_s = rst;
            @(negedge clk);
            if (!rst_s && rda && (!rda_prev || ack_s)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected byte: got %0h expected none", rx_data);
                end else begin
                    chk("rx byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            rda_prev = rst_s ? 1'b0 : rda;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int divs[4];
        divs = '{D0, D1, D2, D3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rx_data", {24'h0, rx_data}, 32'h0);
        chk("reset rda", rda, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);

        // Single byte with exact delivery latency
        fork
            send_byte(8'hA5, 1'b1, 64, 1'b1);
            begin
                @(negedge clk);
                wait_rda(700, n);
            end
        join
        chk("A5 latency", n, 611);
        chk("A5 frame_err", frame_err, 0);
        chk("A5 overrun", overrun, 0);
        pulse_ack();
        chk("A5 rda after ack", rda, 0);
        chk("A5 data held", {24'h0, rx_data}, 32'hA5);

        // Glitch shorter than half a bit
        repeat (20) @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        chk("glitch busy before", busy, 0);
        @(negedge clk);
        chk("glitch busy rises", busy, 1);
        repeat (13) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch busy", busy, 0);
        chk("glitch rda", rda, 0);
        chk("glitch flags", {frame_err, overrun}, 0);

        // Framing error and break
        send_byte(8'h3C, 1'b0, 64, 1'b0);
        repeat (200) @(negedge clk);
        chk("fe set", frame_err, 1);
        chk("fe rda", rda, 0);
        chk("fe in break", busy, 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("fe break exit", busy, 0);
        pulse_clr();
        chk("fe cleared", frame_err, 0);

        // Overrun: second byte dropped
        repeat (20) @(negedge clk);
        send_byte(8'h11, 1'b1, 64, 1'b1);
        send_byte(8'h22, 1'b1, 64, 1'b0);
        repeat (20) @(negedge clk);
        chk("ovr data", {24'h0, rx_data}, 32'h11);
        chk("ovr rda", rda, 1);
        chk("ovr flag", overrun, 1);
        pulse_clr();
        chk("ovr cleared", overrun, 0);
        pulse_ack();

        // Ack in the exact delivery cycle of byte 2 frees the slot
        send_byte(8'h11, 1'b1, 64, 1'b1);
        fork
            send_byte(8'h22, 1'b1, 64, 1'b1);
            begin
                @(negedge clk);
                repeat (610) @(negedge clk);
                pulse_ack();
            end
        join
        repeat (20) @(negedge clk);
        chk("ack-same data", {24'h0, rx_data}, 32'h22);
        chk("ack-same rda", rda, 1);
        chk("ack-same overrun", overrun, 0);
        pulse_ack();

        // Baud select
        for (int c = 0; c < 4; c++) begin
            repeat (10) @(negedge clk);
            br_cfg = 2'(c);
            fork
                begin
                    send_byte(8'hFF, 1'b1, 16 * divs[c], 1'b1);
                    send_byte(8'h00, 1'b1, 16 * divs[c], 1'b1);
                end
                begin
                    for (int k = 0; k < 2; k++) begin
                        wait_rda(3000, n);
                        chk($sformatf("baud%0d byte%0d arrived", c, k), rda, 1);
                        pulse_ack();
                    end
                end
            join
            chk($sformatf("baud%0d flags", c), {frame_err, overrun}, 0);
        end
        br_cfg = 2'd0;

        // Reset in the middle of bit 3 of 0x5A
        repeat (20) @(negedge clk);
        send_bit(1'b0, 64);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h5A >> i), 64);
        @(negedge clk);
        rxd = 1'(8'h5A >> 3);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst rda", rda, 0);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst idle", busy, 0);
        send_byte(8'h81, 1'b1, 64, 1'b1);
        repeat (20) @(negedge clk);
        chk("rst 81 rda", rda, 1);
        chk("rst flags", {frame_err, overrun}, 0);
        pulse_ack();

        repeat (50) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
